// File: rtl/codifica_hamming_tx_pkg.sv
// Shared definitions for the Hamming(15,11) transmitter and its corrector.
// Codeword vector index i holds Hamming position i+1.
package codifica_hamming_tx_pkg;

    localparam int LARG_DADO = 11;
    localparam int LARG_COD  = 15;
    localparam int LARG_POS  = 4;
    localparam int LARG_CNT  = 4;

    // Parity bit locations inside the codeword vector
    localparam int IDX_P1 = 0;
    localparam int IDX_P2 = 1;
    localparam int IDX_P4 = 3;
    localparam int IDX_P8 = 7;

    // Last bit counter value of a frame
    localparam logic [LARG_CNT-1:0] CNT_ULTIMO = 4'd14;

    typedef enum logic {
        OCIOSO    = 1'b0,
        TRANSMITE = 1'b1
    } estado_t;

    // Codeword vector index holding data bit i (d0..d10)
    function automatic logic [LARG_POS-1:0] idx_dado(input int i);
        logic [LARG_POS-1:0] idx;
        case (i)
            0:       idx = 4'd2;
            1:       idx = 4'd4;
            2:       idx = 4'd5;
            3:       idx = 4'd6;
            4:       idx = 4'd8;
            5:       idx = 4'd9;
            6:       idx = 4'd10;
            7:       idx = 4'd11;
            8:       idx = 4'd12;
            9:       idx = 4'd13;
            default: idx = 4'd14;
        endcase
        return idx;
    endfunction

    // Syndrome of a received codeword: position of the flipped bit, 0 if clean
    function automatic logic [LARG_POS-1:0] sindrome(input logic [LARG_COD-1:0] cod);
        logic [LARG_POS-1:0] s;
        s = '0;
        for (int i = 0; i < LARG_COD; i++) begin
            if (cod[i]) begin
                s = s ^ LARG_POS'(i + 1);
            end
        end
        return s;
    endfunction

    // Gathers the data bits back out of a codeword
    function automatic logic [LARG_DADO-1:0] extrai_dado(input logic [LARG_COD-1:0] cod);
        logic [LARG_DADO-1:0] d;
        d = '0;
        for (int i = 0; i < LARG_DADO; i++) begin
            d[i] = cod[idx_dado(i)];
        end
        return d;
    endfunction

endpackage

// File: rtl/codifica_hamming_tx_gera_hamming.sv
// Combinational Hamming(15,11) encoder with optional single-bit flip.
module codifica_hamming_tx_gera_hamming
    import codifica_hamming_tx_pkg::*;
(
    input  logic [LARG_DADO-1:0] i_dado,
    input  logic [LARG_POS-1:0]  i_injeta_erro,
    output logic [LARG_COD-1:0]  o_palavra
);

    logic [LARG_COD-1:0] w_base;
    logic [LARG_COD-1:0] w_mascara;

    // Scatter data into its slots, then fill the four parity slots
    always_comb begin
        w_base = '0;
        for (int i = 0; i < LARG_DADO; i++) begin
            w_base[idx_dado(i)] = i_dado[i];
        end
        w_base[IDX_P1] = w_base[2] ^ w_base[4] ^ w_base[6] ^ w_base[8]
                       ^ w_base[10] ^ w_base[12] ^ w_base[14];
        w_base[IDX_P2] = w_base[2] ^ w_base[5] ^ w_base[6] ^ w_base[9]
                       ^ w_base[10] ^ w_base[13] ^ w_base[14];
        w_base[IDX_P4] = w_base[4] ^ w_base[5] ^ w_base[6] ^ w_base[11]
                       ^ w_base[12] ^ w_base[13] ^ w_base[14];
        w_base[IDX_P8] = w_base[8] ^ w_base[9] ^ w_base[10] ^ w_base[11]
                       ^ w_base[12] ^ w_base[13] ^ w_base[14];
    end

    // One-hot flip mask; position 0 selects nothing
    always_comb begin
        w_mascara = '0;
        for (int i = 0; i < LARG_COD; i++) begin
            w_mascara[i] = (i_injeta_erro == LARG_POS'(i + 1));
        end
    end

    assign o_palavra = w_base ^ w_mascara;

endmodule

// File: rtl/codifica_hamming_tx.sv
// Hamming(15,11) serial transmitter: encodes accepted words and shifts them
// out LSB first, with a one-word holding buffer for gapless frames.
//
// Handshake: a word transfers on a rising edge where i_dado_valido and
// o_dado_pronto are both high. o_dado_pronto depends only on the buffer
// state (and reset), never on i_dado_valido. While o_dado_pronto is low the
// upstream must hold i_dado/i_injeta_erro stable; they are not sampled.
module codifica_hamming_tx
    import codifica_hamming_tx_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [LARG_DADO-1:0] i_dado,
    input  logic [LARG_POS-1:0]  i_injeta_erro,
    input  logic                 i_dado_valido,
    output logic                 o_dado_pronto,
    output logic                 o_serial_out,
    output logic                 o_serial_valido,
    output logic                 o_inicio_quadro,
    output logic [LARG_COD-1:0]  o_palavra,
    output estado_t              o_estado
);

    estado_t             r_estado;
    logic [LARG_CNT-1:0] r_cnt;
    logic [LARG_COD-1:0] r_shift;
    logic [LARG_COD-1:0] r_palavra;
    logic [LARG_COD-1:0] r_buf;
    logic                r_buf_cheio;

    estado_t             w_estado_prox;
    logic [LARG_CNT-1:0] w_cnt_prox;
    logic [LARG_COD-1:0] w_shift_prox;
    logic [LARG_COD-1:0] w_palavra_prox;
    logic [LARG_COD-1:0] w_buf_prox;
    logic                w_buf_cheio_prox;

    logic [LARG_COD-1:0] w_codificado;
    logic                w_transfere;

    codifica_hamming_tx_gera_hamming u_gera_hamming (
        .i_dado        (i_dado),
        .i_injeta_erro (i_injeta_erro),
        .o_palavra     (w_codificado)
    );

    assign o_dado_pronto = !r_buf_cheio && !i_rst;
    assign w_transfere   = i_dado_valido && o_dado_pronto;

    // State, counter, shift register, frame copy and holding buffer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_estado    <= OCIOSO;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_palavra   <= '0;
            r_buf       <= '0;
            r_buf_cheio <= 1'b0;
        end else begin
            r_estado    <= w_estado_prox;
            r_cnt       <= w_cnt_prox;
            r_shift     <= w_shift_prox;
            r_palavra   <= w_palavra_prox;
            r_buf       <= w_buf_prox;
            r_buf_cheio <= w_buf_cheio_prox;
        end
    end

    // Next-state: start frames, shift bits, chain buffered frames at cnt 14
    always_comb begin
        w_estado_prox    = r_estado;
        w_cnt_prox       = r_cnt;
        w_shift_prox     = r_shift;
        w_palavra_prox   = r_palavra;
        w_buf_prox       = r_buf;
        w_buf_cheio_prox = r_buf_cheio;
        case (r_estado)
            OCIOSO: begin
                if (w_transfere) begin
                    w_estado_prox  = TRANSMITE;
                    w_cnt_prox     = '0;
                    w_shift_prox   = w_codificado;
                    w_palavra_prox = w_codificado;
                end
            end
            TRANSMITE: begin
                if (r_cnt == CNT_ULTIMO) begin
                    w_cnt_prox = '0;
                    if (r_buf_cheio) begin
                        // buffered word follows with no idle cycle
                        w_shift_prox     = r_buf;
                        w_palavra_prox   = r_buf;
                        w_buf_cheio_prox = 1'b0;
                    end else if (w_transfere) begin
                        // word arriving on the last edge goes straight out
                        w_shift_prox   = w_codificado;
                        w_palavra_prox = w_codificado;
                    end else begin
                        w_estado_prox  = OCIOSO;
                        w_shift_prox   = '0;
                        w_palavra_prox = '0;
                    end
                end else begin
                    w_cnt_prox   = r_cnt + 4'd1;
                    w_shift_prox = {1'b0, r_shift[LARG_COD-1:1]};
                    if (w_transfere) begin
                        w_buf_prox       = w_codificado;
                        w_buf_cheio_prox = 1'b1;
                    end
                end
            end
            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    assign o_serial_valido = (r_estado == TRANSMITE);
    assign o_serial_out    = o_serial_valido && r_shift[0];
    assign o_inicio_quadro = o_serial_valido && (r_cnt == '0);
    assign o_palavra       = r_palavra;
    assign o_estado        = r_estado;

endmodule
